// File: rtl/morse_key_classifier.sv
// Telegraph key front end: synchronises the key, times presses and gaps in ticks and emits
// Dot/Dash/Space/EndSeq/ElemErr pulses. Optional debouncer enabled by `define MORSE_DEBOUNCE_EN.
module morse_key_classifier #(
  parameter int CNT_W          = 16,
  parameter int TICK_DIV       = 1000,
  parameter int DEBOUNCE_CYC   = 8,
  parameter int DASH_TICKS     = 3,
  parameter int CHAR_GAP_TICKS = 3,
  parameter int SEQ_GAP_TICKS  = 7,
  parameter int MAX_ELEMS      = 5
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Key,
  output logic Dot,
  output logic Dash,
  output logic Space,
  output logic EndSeq,
  output logic ElemErr,
  output logic Busy
);
  // state | meaning
  // IDLE  | no activity, prescaler parked
  // PRESS | key held, timing press length
  // GAP   | key released inside a character
  // LGAP  | character closed, waiting for sequence gap or next character
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] PRESS = 2'd1;
  localparam logic [1:0] GAP   = 2'd2;
  localparam logic [1:0] LGAP  = 2'd3;

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int EW = $clog2(MAX_ELEMS + 1);
  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [EW-1:0]    ELEM_MAX = EW'(MAX_ELEMS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] DASH_T   = CNT_W'(DASH_TICKS);
  localparam logic [CNT_W-1:0] CHAR_T   = CNT_W'(CHAR_GAP_TICKS);
  localparam logic [CNT_W-1:0] SEQ_T    = CNT_W'(SEQ_GAP_TICKS);

  if (DEBOUNCE_CYC < 1 || TICK_DIV < 1 || SEQ_GAP_TICKS <= CHAR_GAP_TICKS) begin : g_param_check
    $error("morse_key_classifier: inconsistent parameters");
  end

  logic [1:0]       state;
  logic             key_m, key_s, key_d, key_prev;
  logic [PW-1:0]    presc;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [EW-1:0]    elem_cnt;
  logic             key_rise, key_fall, key_edge, tick, gap_char, gap_seq;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      key_m    <= 1'b0;
      key_s    <= 1'b0;
      key_prev <= 1'b0;
    end else begin
      key_m    <= Key;
      key_s    <= key_m;
      key_prev <= key_d;
    end
  end

`ifdef MORSE_DEBOUNCE_EN
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYC - 1);
  logic [DW-1:0] db_cnt;
  logic          key_db;

  // key_db follows key_s only after DEBOUNCE_CYC consecutive disagreeing cycles
  always_ff @(posedge Clk) begin
    if (Reset) begin
      db_cnt <= '0;
      key_db <= 1'b0;
    end else if (key_s == key_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      key_db <= key_s;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end
  assign key_d = key_db;
`else
  assign key_d = key_s;
`endif

  assign key_rise = key_d & ~key_prev;
  assign key_fall = ~key_d & key_prev;
  assign key_edge = key_rise | key_fall;
  assign tick     = (state != IDLE) && (presc == PRE_LAST);
  // The tick landing on an edge cycle still belongs to the interval that edge closes
  assign cnt_next = (tick && cnt != CNT_MAX) ? cnt + 1'b1 : cnt;
  assign gap_char = tick && (cnt_next >= CHAR_T);
  assign gap_seq  = tick && (cnt_next >= SEQ_T);
  assign Busy     = (state != IDLE);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      presc    <= '0;
      cnt      <= '0;
      elem_cnt <= '0;
      Dot      <= 1'b0;
      Dash     <= 1'b0;
      Space    <= 1'b0;
      EndSeq   <= 1'b0;
      ElemErr  <= 1'b0;
    end else begin
      Dot     <= 1'b0;
      Dash    <= 1'b0;
      Space   <= 1'b0;
      EndSeq  <= 1'b0;
      ElemErr <= 1'b0;

      if (key_edge) begin
        presc <= '0;
        cnt   <= '0;
      end else if (tick) begin
        presc <= '0;
        cnt   <= cnt_next;
      end else if (state != IDLE) begin
        presc <= presc + 1'b1;
      end

      case (state)
        IDLE: if (key_rise) state <= PRESS;
        PRESS: begin
          if (key_fall) begin
            state <= GAP;
            if (elem_cnt == ELEM_MAX) begin
              ElemErr <= 1'b1;
            end else begin
              elem_cnt <= elem_cnt + 1'b1;
              if (cnt_next < DASH_T) Dot <= 1'b1;
              else Dash <= 1'b1;
            end
          end
        end
        GAP: begin
          if (gap_char) begin
            Space    <= 1'b1;
            elem_cnt <= '0;
            state    <= key_rise ? PRESS : LGAP;
          end else if (key_rise) begin
            state <= PRESS;
          end
        end
        LGAP: begin
          if (gap_seq) begin
            EndSeq <= 1'b1;
            state  <= key_rise ? PRESS : IDLE;
          end else if (key_rise) begin
            state <= PRESS;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_morse_key_classifier.sv
// Bench for morse_key_classifier (TICK_DIV=1, debounce off): run-length reference model
// computed from the whole key stream, compared every cycle plus per-scenario pulse counts.
module tb_morse_key_classifier;
  localparam int DASH = 3, CHAR = 3, SEQ = 7, MAXE = 5, NMAX = 512;

  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic Key = 1'b0;
  logic Dot, Dash, Space, EndSeq, ElemErr, Busy;

  int compared = 0;
  int mismatched = 0;

  bit stim_q[$];
  logic [5:0] obs[NMAX];
  logic [5:0] expv[NMAX];

  always #5 Clk = ~Clk;

  morse_key_classifier #(
    .CNT_W(16), .TICK_DIV(1), .DEBOUNCE_CYC(4), .DASH_TICKS(DASH),
    .CHAR_GAP_TICKS(CHAR), .SEQ_GAP_TICKS(SEQ), .MAX_ELEMS(MAXE)
  ) dut (
    .Clk(Clk), .Reset(Reset), .Key(Key), .Dot(Dot), .Dash(Dash), .Space(Space),
    .EndSeq(EndSeq), .ElemErr(ElemErr), .Busy(Busy)
  );

  task automatic add(input bit v, input int len);
    repeat (len) stim_q.push_back(v);
  endtask

  // Applies reset, then plays stim_q one cycle per entry, recording outputs after each edge.
  task automatic run_stream();
    Reset = 1'b1;
    Key = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < stim_q.size(); i++) begin
      Key = stim_q[i];
      @(posedge Clk);
      @(negedge Clk);
      obs[i] = {Busy, ElemErr, EndSeq, Space, Dash, Dot};
    end
    Key = 1'b0;
  endtask

  // Reference: key level seen by the classifier lags the pin by two cycles; each press run
  // of L cycles ends with a Dot/Dash/ElemErr, each gap yields Space at +CHAR and EndSeq at +SEQ
  // unless the next press starts strictly earlier. Bits: {Busy,ElemErr,EndSeq,Space,Dash,Dot}.
  task automatic build_model();
    int n, elems, r, f, r2, stop;
    bit kd[NMAX];
    n = stim_q.size();
    elems = 0;
    r = -1;
    for (int p = 0; p < n; p++) begin
      expv[p] = '0;
      kd[p] = (p >= 2) ? stim_q[p-2] : 1'b0;
    end
    for (int p = 1; p < n && r < 0; p++) if (kd[p] && !kd[p-1]) r = p;
    while (r >= 0) begin
      f = r;
      while (f < n && kd[f]) f++;
      for (int q = r; q < f; q++) expv[q][5] = 1'b1;
      if (f >= n) break;
      if (elems == MAXE) expv[f][4] = 1'b1;
      else begin
        if (f - r >= DASH) expv[f][1] = 1'b1;
        else expv[f][0] = 1'b1;
        elems++;
      end
      r2 = f;
      while (r2 < n && !kd[r2]) r2++;
      stop = r2;
      if (f + CHAR <= r2 && f + CHAR < n) begin
        expv[f+CHAR][2] = 1'b1;
        elems = 0;
        if (f + SEQ <= r2 && f + SEQ < n) begin
          expv[f+SEQ][3] = 1'b1;
          stop = f + SEQ;
        end
      end
      for (int q = f; q < stop && q < n; q++) expv[q][5] = 1'b1;
      r = (r2 < n) ? r2 : -1;
    end
  endtask

  function automatic int count_obs(input int bit_idx);
    int c = 0;
    for (int i = 0; i < stim_q.size(); i++) if (obs[i][bit_idx]) c++;
    return c;
  endfunction

  task automatic test_reset();
    Reset = 1'b1;
    Key = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    compared++;
    if ({Busy, ElemErr, EndSeq, Space, Dash, Dot} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_hold: got %b expected 000000", {Busy, ElemErr, EndSeq, Space, Dash, Dot});
    end
    Reset = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
    compared++;
    if ({Busy, ElemErr, EndSeq, Space, Dash, Dot} !== 6'b0) begin
      mismatched++;
      $display("FAIL reset_idle: got %b expected 000000", {Busy, ElemErr, EndSeq, Space, Dash, Dot});
    end
  endtask

  task automatic test_dot_gap();
    stim_q.delete();
    add(1, 2); add(0, 12);
    run_stream();
    build_model();
    for (int i = 0; i < stim_q.size(); i++) begin
      compared++;
      if (obs[i] !== expv[i]) begin
        mismatched++;
        $display("FAIL dot_gap cyc %0d: got %b expected %b", i, obs[i], expv[i]);
      end
    end
    compared++;
    if ({count_obs(0), count_obs(2), count_obs(3), obs[stim_q.size()-1][5]} !== {32'd1, 32'd1, 32'd1, 1'b0}) begin
      mismatched++;
      $display("FAIL dot_gap_counts: dot %0d space %0d endseq %0d busy %b expected 1 1 1 0",
               count_obs(0), count_obs(2), count_obs(3), obs[stim_q.size()-1][5]);
    end
    compared++;
    if (obs[7][2] !== 1'b1 || obs[11][3] !== 1'b1) begin
      mismatched++;
      $display("FAIL dot_gap_timing: space@7=%b endseq@11=%b expected 1 1", obs[7][2], obs[11][3]);
    end
  endtask

  task automatic test_dash_dot();
    stim_q.delete();
    add(1, 5); add(0, 2); add(1, 1); add(0, 12);
    run_stream();
    build_model();
    for (int i = 0; i < stim_q.size(); i++) begin
      compared++;
      if (obs[i] !== expv[i]) begin
        mismatched++;
        $display("FAIL dash_dot cyc %0d: got %b expected %b", i, obs[i], expv[i]);
      end
    end
    compared++;
    if ({count_obs(1), count_obs(0), count_obs(2), count_obs(3)} !== {32'd1, 32'd1, 32'd1, 32'd1}) begin
      mismatched++;
      $display("FAIL dash_dot_counts: dash %0d dot %0d space %0d endseq %0d expected 1 1 1 1",
               count_obs(1), count_obs(0), count_obs(2), count_obs(3));
    end
  endtask

  task automatic test_elem_limit();
    stim_q.delete();
    repeat (6) begin add(1, 1); add(0, 1); end
    add(0, 12);
    run_stream();
    build_model();
    for (int i = 0; i < stim_q.size(); i++) begin
      compared++;
      if (obs[i] !== expv[i]) begin
        mismatched++;
        $display("FAIL elem_limit cyc %0d: got %b expected %b", i, obs[i], expv[i]);
      end
    end
    compared++;
    if ({count_obs(0), count_obs(4), count_obs(2), count_obs(1)} !== {32'd5, 32'd1, 32'd1, 32'd0}) begin
      mismatched++;
      $display("FAIL elem_limit_counts: dot %0d elemerr %0d space %0d dash %0d expected 5 1 1 0",
               count_obs(0), count_obs(4), count_obs(2), count_obs(1));
    end
  endtask

  // Rises landing exactly on the char and seq thresholds, then a restart inside LGAP.
  task automatic test_boundaries();
    stim_q.delete();
    add(1, 1); add(0, CHAR); add(1, 1); add(0, SEQ); add(1, 1); add(0, 6);
    add(1, 1); add(0, 12);
    run_stream();
    build_model();
    for (int i = 0; i < stim_q.size(); i++) begin
      compared++;
      if (obs[i] !== expv[i]) begin
        mismatched++;
        $display("FAIL boundaries cyc %0d: got %b expected %b", i, obs[i], expv[i]);
      end
    end
    compared++;
    if ({count_obs(0), count_obs(2), count_obs(3), count_obs(4)} !== {32'd4, 32'd4, 32'd2, 32'd0}) begin
      mismatched++;
      $display("FAIL boundaries_counts: dot %0d space %0d endseq %0d elemerr %0d expected 4 4 2 0",
               count_obs(0), count_obs(2), count_obs(3), count_obs(4));
    end
  endtask

  task automatic test_reset_mid_press();
    int dash_seen, dot_seen;
    Reset = 1'b1;
    Key = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    Key = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    compared++;
    if (Busy !== 1'b1) begin
      mismatched++;
      $display("FAIL mid_press_busy: got %b expected 1", Busy);
    end
    Reset = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    compared++;
    if ({Busy, ElemErr, EndSeq, Space, Dash, Dot} !== 6'b0) begin
      mismatched++;
      $display("FAIL mid_press_reset: got %b expected 000000", {Busy, ElemErr, EndSeq, Space, Dash, Dot});
    end
    Reset = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    Key = 1'b0;
    dash_seen = 0;
    dot_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge Clk);
      @(negedge Clk);
      if (Dash) dash_seen++;
      if (Dot) dot_seen++;
    end
    compared++;
    if (dash_seen !== 0 || dot_seen !== 1) begin
      mismatched++;
      $display("FAIL mid_press_after: dash %0d dot %0d expected 0 1", dash_seen, dot_seen);
    end
  endtask

  task automatic test_random();
    for (int s = 0; s < 12; s++) begin
      int nel;
      stim_q.delete();
      add(0, $urandom_range(0, 3));
      nel = $urandom_range(3, 9);
      for (int e = 0; e < nel; e++) begin
        add(1, $urandom_range(1, 6));
        add(0, $urandom_range(1, 9));
      end
      add(0, SEQ + 4);
      run_stream();
      build_model();
      for (int i = 0; i < stim_q.size(); i++) begin
        compared++;
        if (obs[i] !== expv[i]) begin
          mismatched++;
          $display("FAIL random s%0d cyc %0d: got %b expected %b", s, i, obs[i], expv[i]);
        end
        compared++;
        if ($countones(obs[i][4:0]) > 1) begin
          mismatched++;
          $display("FAIL random_excl s%0d cyc %0d: got %b expected at most one pulse", s, i, obs[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_dot_gap();
    test_dash_dot();
    test_elem_limit();
    test_boundaries();
    test_reset_mid_press();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
